regfile_param_bank: RTL and testbench

// - Parametrised per-engine register bank: N_RW config regs, N_RO status regs and one CTRL reg, at BASE_ADDR.
// - Adds a start/busy/done/irq handshake with the engine, registered reads and a bus error pulse.
// - Sits between the register-interface address decoder and one compute engine (pool, conv, ...).

---
 rtl/regfile_param_bank.sv | 130 +++++++++++++
 tb/tb_regfile_param_bank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param_bank.sv
// Per-engine register bank: N_RW config regs, N_RO status regs and a CTRL reg with start/busy/done/irq handshake.
// Optional macro REGFILE_SHADOW_EN stages config writes and loads cfg_o atomically on each accepted start.
//
// state | meaning
// IDLE  | engine idle, BUSY=0, a CTRL start is accepted
// RUN   | engine running, BUSY=1, waiting for done_i
module regfile_param_bank #(
    parameter int                ADDR_W    = 14,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 14'h200,
    parameter int                N_RW      = 8,
    parameter int                N_RO      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        write_data,
    output logic [DATA_W-1:0]        read_data,
    output logic                     rd_valid,
    output logic                     bus_err,
    output logic [N_RW*DATA_W-1:0]   cfg_o,
    input  logic [N_RO*DATA_W-1:0]   status_i,
    output logic                     start_o,
    input  logic                     done_i,
    output logic                     irq_o
);

    localparam logic [ADDR_W-1:0] OFF_LAST_RW = ADDR_W'(N_RW);
    localparam logic [ADDR_W-1:0] OFF_CTRL    = ADDR_W'(N_RW + N_RO + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state;
    logic [DATA_W-1:0]   rw_q [N_RW];
    logic                done_q;
    logic                irq_en_q;

    logic [ADDR_W-1:0]   off;
    logic                in_range;
    logic                is_ctrl;
    logic                is_ro;
    logic                ctrl_wr;
    logic                start_ok;
    logic                start_rej;
    logic                done_hit;
    logic                err_next;
    logic [DATA_W-1:0]   rd_val;

    always_comb begin
        off       = addr - BASE_ADDR;
        in_range  = (addr >= BASE_ADDR) && (off >= ADDR_W'(1)) && (off <= OFF_CTRL);
        is_ctrl   = in_range && (off == OFF_CTRL);
        is_ro     = in_range && (off > OFF_LAST_RW) && (off < OFF_CTRL);
        ctrl_wr   = wr_en && is_ctrl;
        // Start is judged against the pre-edge BUSY, so a start racing done_i is rejected.
        start_ok  = ctrl_wr && write_data[0] && (state == IDLE);
        start_rej = ctrl_wr && write_data[0] && (state == RUN);
        done_hit  = done_i && (state == RUN);
        err_next  = (wr_en && (!in_range || is_ro)) || (rd_en && !in_range) || start_rej;

        rd_val = '0;
        for (int k = 0; k < N_RW; k++) begin
            if (in_range && off == ADDR_W'(k + 1)) rd_val = rw_q[k];
        end
        for (int k = 0; k < N_RO; k++) begin
            if (in_range && off == ADDR_W'(N_RW + k + 1)) rd_val = status_i[k*DATA_W +: DATA_W];
        end
        if (is_ctrl) rd_val[3:1] = {irq_en_q, done_q, (state == RUN)};
    end

`ifdef REGFILE_SHADOW_EN
    logic [DATA_W-1:0] cfg_q [N_RW];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            read_data <= '0;
            rd_valid  <= 1'b0;
            bus_err   <= 1'b0;
            start_o   <= 1'b0;
            irq_o     <= 1'b0;
            for (int k = 0; k < N_RW; k++) rw_q[k] <= '0;
`ifdef REGFILE_SHADOW_EN
            for (int k = 0; k < N_RW; k++) cfg_q[k] <= '0;
`endif
        end else begin
            rd_valid  <= rd_en;
            read_data <= rd_en ? rd_val : '0;
            bus_err   <= err_next;
            start_o   <= start_ok;
            irq_o     <= done_q & irq_en_q;

            for (int k = 0; k < N_RW; k++) begin
                if (wr_en && in_range && off == ADDR_W'(k + 1)) rw_q[k] <= write_data;
            end

            if (ctrl_wr) irq_en_q <= write_data[3];

            // A completing engine wins over a same-cycle W1C.
            if (done_hit)                      done_q <= 1'b1;
            else if (ctrl_wr && write_data[2]) done_q <= 1'b0;

            case (state)
                IDLE:    if (start_ok) state <= RUN;
                RUN:     if (done_hit) state <= IDLE;
                default: state <= IDLE;
            endcase

`ifdef REGFILE_SHADOW_EN
            if (start_ok) begin
                for (int k = 0; k < N_RW; k++) cfg_q[k] <= rw_q[k];
            end
`endif
        end
    end

    for (genvar g = 0; g < N_RW; g++) begin : g_cfg
`ifdef REGFILE_SHADOW_EN
        assign cfg_o[g*DATA_W +: DATA_W] = cfg_q[g];
`else
        assign cfg_o[g*DATA_W +: DATA_W] = rw_q[g];
`endif
    end

endmodule

// File: tb/tb_regfile_param_bank.sv
// Directed bench for regfile_param_bank: decode, RW/RO access, CTRL handshake, races and reset.
module tb_regfile_param_bank;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [13:0]   addr;
    logic [15:0]   write_data;
    logic [15:0]   read_data;
    logic          rd_valid;
    logic          bus_err;
    logic [127:0]  cfg_o;
    logic [47:0]   status_i;
    logic          start_o;
    logic          done_i;
    logic          irq_o;

    int checks = 0;
    int errors = 0;

    regfile_param_bank dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .rd_valid   (rd_valid),
        .bus_err    (bus_err),
        .cfg_o      (cfg_o),
        .status_i   (status_i),
        .start_o    (start_o),
        .done_i     (done_i),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [13:0] a, input logic [15:0] d);
        wr_en = 1'b1; addr = a; write_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [13:0] a);
        rd_en = 1'b1; addr = a;
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        rst = 1'b0;
        cyc(); cyc();
        checks++; if (cfg_o !== 128'h0) begin errors++; $display("FAIL reset_cfg got %h exp 0", cfg_o); end
        checks++; if (read_data !== 16'h0) begin errors++; $display("FAIL reset_read_data got %h exp 0", read_data); end
        checks++; if (start_o !== 1'b0 || irq_o !== 1'b0 || rd_valid !== 1'b0 || bus_err !== 1'b0) begin
            errors++; $display("FAIL reset_outs got start=%b irq=%b rv=%b err=%b exp 0", start_o, irq_o, rd_valid, bus_err);
        end
        rst = 1'b1;
        cyc();
        for (int k = 1; k <= 12; k++) begin
            bus_rd(14'h200 + 14'(k));
            if (k >= 9 && k <= 11) exp = status_i[(k-9)*16 +: 16];
            else exp = 16'h0;
            checks++; if (read_data !== exp || rd_valid !== 1'b1) begin
                errors++; $display("FAIL reset_read_off%0d got %h rv=%b exp %h rv=1", k, read_data, rd_valid, exp);
            end
        end
    endtask

    task automatic test_rw();
        logic [15:0] exp_cfg0;
`ifdef REGFILE_SHADOW_EN
        exp_cfg0 = 16'h0000;
`else
        exp_cfg0 = 16'h00A5;
`endif
        bus_wr(14'h201, 16'h00A5);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rw_wr_err got %b exp 0", bus_err); end
        checks++; if (cfg_o[15:0] !== exp_cfg0) begin errors++; $display("FAIL rw_cfg0 got %h exp %h", cfg_o[15:0], exp_cfg0); end
        bus_rd(14'h201);
        checks++; if (read_data !== 16'h00A5 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL rw_read got %h rv=%b exp 00a5 rv=1", read_data, rd_valid);
        end
        cyc();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rw_rv_pulse got %b exp 0", rd_valid); end
        bus_wr(14'h208, 16'hBEEF);
        bus_rd(14'h208);
        checks++; if (read_data !== 16'hBEEF) begin errors++; $display("FAIL rw_read8 got %h exp beef", read_data); end
    endtask

    task automatic test_ro_write();
        bus_wr(14'h209, 16'hFFFF);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL ro_wr_err got %b exp 1", bus_err); end
        bus_rd(14'h209);
        checks++; if (read_data !== 16'h1111 || bus_err !== 1'b0) begin
            errors++; $display("FAIL ro_read got %h err=%b exp 1111 err=0", read_data, bus_err);
        end
    endtask

    task automatic test_same_cycle();
        wr_en = 1'b1; rd_en = 1'b1; addr = 14'h202; write_data = 16'h1234;
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (read_data !== 16'h0000 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL same_cycle_pre got %h rv=%b exp 0000 rv=1", read_data, rd_valid);
        end
        bus_rd(14'h202);
        checks++; if (read_data !== 16'h1234) begin errors++; $display("FAIL same_cycle_post got %h exp 1234", read_data); end
    endtask

    task automatic test_start_done();
        bus_wr(14'h20C, 16'h0009);
        checks++; if (start_o !== 1'b1 || bus_err !== 1'b0) begin
            errors++; $display("FAIL start_pulse got start=%b err=%b exp 1 0", start_o, bus_err);
        end
        bus_rd(14'h20C);
        checks++; if (start_o !== 1'b0) begin errors++; $display("FAIL start_one_cycle got %b exp 0", start_o); end
        checks++; if (read_data !== 16'h000A) begin errors++; $display("FAIL ctrl_busy got %h exp 000a", read_data); end
        bus_wr(14'h20C, 16'h0009);
        checks++; if (start_o !== 1'b0 || bus_err !== 1'b1) begin
            errors++; $display("FAIL start_while_busy got start=%b err=%b exp 0 1", start_o, bus_err);
        end
        done_i = 1'b1; cyc(); done_i = 1'b0;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_lag got %b exp 0", irq_o); end
        cyc();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq_o); end
        bus_rd(14'h20C);
        checks++; if (read_data !== 16'h000C) begin errors++; $display("FAIL ctrl_done got %h exp 000c", read_data); end
    endtask

    task automatic test_done_w1c_race();
        bus_wr(14'h20C, 16'h000C);
        cyc();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL w1c_irq_clear got %b exp 0", irq_o); end
        bus_wr(14'h20C, 16'h0009);
        checks++; if (start_o !== 1'b1) begin errors++; $display("FAIL race_start got %b exp 1", start_o); end
        done_i = 1'b1;
        bus_wr(14'h20C, 16'h000C);
        done_i = 1'b0;
        bus_rd(14'h20C);
        checks++; if (read_data !== 16'h000C) begin errors++; $display("FAIL done_beats_w1c got %h exp 000c", read_data); end
        bus_wr(14'h20C, 16'h000C);
        bus_rd(14'h20C);
        checks++; if (read_data !== 16'h0008) begin errors++; $display("FAIL w1c_done got %h exp 0008", read_data); end
    endtask

    task automatic test_done_start_race();
        bus_wr(14'h20C, 16'h0009);
        done_i = 1'b1;
        bus_wr(14'h20C, 16'h0009);
        done_i = 1'b0;
        checks++; if (start_o !== 1'b0 || bus_err !== 1'b1) begin
            errors++; $display("FAIL done_start_race got start=%b err=%b exp 0 1", start_o, bus_err);
        end
        bus_rd(14'h20C);
        checks++; if (read_data !== 16'h000C) begin errors++; $display("FAIL done_start_ctrl got %h exp 000c", read_data); end
        bus_wr(14'h20C, 16'h000C);
        done_i = 1'b1; cyc(); done_i = 1'b0;
        bus_rd(14'h20C);
        checks++; if (read_data !== 16'h0008) begin errors++; $display("FAIL done_idle_ignored got %h exp 0008", read_data); end
    endtask

    task automatic test_shadow();
        logic [15:0] exp_busy;
`ifdef REGFILE_SHADOW_EN
        exp_busy = 16'h00A5;
`else
        exp_busy = 16'h0003;
`endif
        bus_wr(14'h20C, 16'h0009);
        bus_wr(14'h201, 16'h0003);
        checks++; if (cfg_o[15:0] !== exp_busy) begin errors++; $display("FAIL cfg_while_busy got %h exp %h", cfg_o[15:0], exp_busy); end
        bus_rd(14'h201);
        checks++; if (read_data !== 16'h0003) begin errors++; $display("FAIL stage_read got %h exp 0003", read_data); end
        done_i = 1'b1; cyc(); done_i = 1'b0;
        bus_wr(14'h20C, 16'h0009);
        checks++; if (start_o !== 1'b1 || cfg_o[15:0] !== 16'h0003) begin
            errors++; $display("FAIL cfg_on_start got start=%b cfg=%h exp 1 0003", start_o, cfg_o[15:0]);
        end
        done_i = 1'b1; cyc(); done_i = 1'b0;
        bus_wr(14'h20C, 16'h000C);
    endtask

    task automatic test_unmapped();
        bus_rd(14'h1FF);
        checks++; if (read_data !== 16'h0 || rd_valid !== 1'b1 || bus_err !== 1'b1) begin
            errors++; $display("FAIL unmapped_rd_1ff got %h rv=%b err=%b exp 0 1 1", read_data, rd_valid, bus_err);
        end
        bus_rd(14'h20D);
        checks++; if (read_data !== 16'h0 || rd_valid !== 1'b1 || bus_err !== 1'b1) begin
            errors++; $display("FAIL unmapped_rd_20d got %h rv=%b err=%b exp 0 1 1", read_data, rd_valid, bus_err);
        end
        bus_wr(14'h200, 16'hFFFF);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL unmapped_wr_200 got %b exp 1", bus_err); end
        cyc();
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL bus_err_pulse got %b exp 0", bus_err); end
    endtask

    task automatic test_reset_mid_run();
        bus_wr(14'h20C, 16'h0009);
        checks++; if (start_o !== 1'b1) begin errors++; $display("FAIL mid_run_start got %b exp 1", start_o); end
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        checks++; if (start_o !== 1'b0 || irq_o !== 1'b0 || cfg_o !== 128'h0) begin
            errors++; $display("FAIL mid_run_reset got start=%b irq=%b cfg0=%h exp 0 0 0", start_o, irq_o, cfg_o[15:0]);
        end
        cyc();
        checks++; if (start_o !== 1'b0) begin errors++; $display("FAIL mid_run_no_restart got %b exp 0", start_o); end
        bus_rd(14'h20C);
        checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL mid_run_ctrl got %h exp 0000", read_data); end
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; write_data = '0; done_i = 1'b0;
        status_i = {16'h3333, 16'h2222, 16'h1111};
        test_reset();
        test_rw();
        test_ro_write();
        test_same_cycle();
        test_start_done();
        test_done_w1c_race();
        test_done_start_race();
        test_shadow();
        test_unmapped();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
